display_sequencer: RTL and testbench
====================================

Name: display_sequencer

Overview:
- Controller that drives the calculator's 7-segment display path.
- Decides what is shown: blank, operand A, operand B, or the low or high 16-bit page of the 32-bit result.
- Accepts results from the ALU over a valid/ack handshake.
- Sits between the input/ALU control logic and the display top-level; its outputs feed that block's display_mode and chosen_operand inputs plus the result-half mux.

Parameters:
- PAGE_TICKS, 100_000_000, clk cycles between automatic result-page toggles (≥2).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- clear  input  1  single-cycle pulse: blank the display
- op_sel_a  input  1  single-cycle pulse: user is editing operand A
- op_sel_b  input  1  single-cycle pulse: user is editing operand B
- btn_page  input  1  single-cycle debounced pulse: toggle result page
- result_valid  input  1  ALU result ready; held high until result_ack
- result_hi_nz  input  1  result[31:16] != 0, sampled together with result_valid
- result_ack  output  1  one-cycle acknowledge of result_valid
- display_mode  output  2  00 blank, 01 operand, 10 result
- chosen_operand  output  2  01 A, 10 B, 00 otherwise
- result_page  output  1  0 selects result[15:0], 1 selects result[31:16]
- page_dot  output  1  high-page indicator for the decimal point

Behaviour:
- All outputs are registered.
- Reset values: display_mode=00, chosen_operand=00, result_page=0, page_dot=0, result_ack=0, state=IDLE, page timer=0, hi_nz_q=0.
- States and output encoding:
  - IDLE: display_mode 00, chosen_operand 00.
  - SHOW_A: display_mode 01, chosen_operand 01.
  - SHOW_B: display_mode 01, chosen_operand 10.
  - SHOW_RES: display_mode 10, chosen_operand 00.
- Event priority when events coincide: clear > result accept > op_sel_a > op_sel_b > btn_page.
- Transitions from any state:
  - clear → IDLE.
  - accept → SHOW_RES.
  - op_sel_a → SHOW_A.
  - op_sel_b → SHOW_B.
  - op_sel_a and op_sel_b in the same cycle: A wins.
- Result accept:
  - Accept condition: result_valid && !result_ack.
  - On accept: latch hi_nz_q ← result_hi_nz, set result_page=0, clear the page timer, assert result_ack in the next cycle for exactly one cycle.
  - The requester drops result_valid after seeing ack.
  - A valid still high in the ack cycle is not re-accepted.
  - A new accept while already in SHOW_RES restarts at page 0.
- Accept coinciding with clear: clear wins and no ack is issued; valid stays pending and is accepted on a following cycle.
- Latency: result_valid seen high at edge N gives display_mode=10 after edge N and result_ack=1 after edge N+1.
- btn_page:
  - Toggles result_page and clears the page timer only when state=SHOW_RES and hi_nz_q=1.
  - Ignored in all other cases.
- Leaving SHOW_RES forces result_page=0 and hi_nz_q=0.
- page_dot = result_page while in SHOW_RES, 0 otherwise; it is updated in the same cycle as result_page.
- Page timer:
  - Width $clog2(PAGE_TICKS).
  - Runs only in SHOW_RES with hi_nz_q=1.
  - Counts 0..PAGE_TICKS-1, then wraps to 0.
  - Held at 0 otherwise.
- Reset mid-operation (including mid-handshake): returns to reset values immediately; a pending result_valid is re-accepted after reset deasserts.

Optional Feature:
- Macro: DISPLAY_SEQ_AUTO_PAGE_EN.
- Defined: on timer wrap, result_page toggles (page_dot follows), so wide results alternate halves every PAGE_TICKS cycles. A btn_page toggle also clears the timer.
- Undefined: timer logic is omitted; paging is manual via btn_page only.
- Reset values, handshake and state behaviour are identical in both builds.

Decomposition:
- Shared package display_seq_pkg:
  - State enum: IDLE, SHOW_A, SHOW_B, SHOW_RES.
  - Mode constants: MODE_BLANK=2'b00, MODE_OPERAND=2'b01, MODE_RESULT=2'b10.
  - Operand constants: OPERAND_NONE=2'b00, OPERAND_A=2'b01, OPERAND_B=2'b10.
  - These are reused by the display top-level.
- Sub-module page_timer:
  - Parameter PAGE_TICKS.
  - Inputs: clk, reset, run, restart.
  - Output: wrap pulse.
  - Instantiated only under DISPLAY_SEQ_AUTO_PAGE_EN.

Test Plan (PAGE_TICKS=8):
- Reset check: hold reset 3 cycles, release → display_mode=00, chosen_operand=00, result_page=0, result_ack=0; then op_sel_a pulse → mode 01, operand 01 next cycle.
- Handshake: raise result_valid with result_hi_nz=0 at cycle 10, drop it after ack → mode=10 at cycle 11, result_ack=1 only at cycle 12; btn_page at cycle 15 → result_page stays 0.
- Wide result, macro defined: accept with result_hi_nz=1 → result_page toggles 0→1→0 every 8 cycles and page_dot mirrors it; btn_page mid-period → immediate toggle and a full 8-cycle period restarts.
- Priority: clear, result_valid and op_sel_a in the same cycle → IDLE with no ack; next cycle valid is accepted → SHOW_RES and ack follows.
- Simultaneous op_sel_a and op_sel_b → SHOW_A; then op_sel_b alone → mode 01, operand 10, result_page=0.
- Reset during SHOW_RES, page 1, ack cycle → all outputs return to reset values the next cycle; result_valid still high → re-accepted after reset deasserts, with exactly one ack.

Source files
------------

// File: rtl/display_seq_pkg.sv
// Shared state and display-encoding definitions for the calculator display path.
// Also imported by the display top-level for its display_mode / chosen_operand decode.
package display_seq_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHOW_A   = 2'd1,
    SHOW_B   = 2'd2,
    SHOW_RES = 2'd3
  } state_e;

  localparam logic [1:0] MODE_BLANK   = 2'b00;
  localparam logic [1:0] MODE_OPERAND = 2'b01;
  localparam logic [1:0] MODE_RESULT  = 2'b10;

  localparam logic [1:0] OPERAND_NONE = 2'b00;
  localparam logic [1:0] OPERAND_A    = 2'b01;
  localparam logic [1:0] OPERAND_B    = 2'b10;

endpackage

// File: rtl/page_timer.sv
// Free-running page period counter; pulses wrap on the last tick of each period.
// Only instantiated when DISPLAY_SEQ_AUTO_PAGE_EN is defined.
module page_timer #(
  parameter int unsigned PAGE_TICKS = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic restart,
  output logic wrap
);

  localparam int unsigned W = (PAGE_TICKS > 1) ? $clog2(PAGE_TICKS) : 1;
  localparam logic [W-1:0] LastCount = W'(PAGE_TICKS - 1);

  logic [W-1:0] count_q;

  assign wrap = run && !restart && (count_q == LastCount);

  always_ff @(posedge clk) begin
    if (reset || restart || !run) begin
      count_q <= '0;
    end else if (count_q == LastCount) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + W'(1);
    end
  end

endmodule

// File: rtl/display_sequencer.sv
// Display content sequencer: blank / operand A / operand B / result pages, ALU result handshake.
// Define DISPLAY_SEQ_AUTO_PAGE_EN to alternate result halves automatically every PAGE_TICKS.
module display_sequencer
  import display_seq_pkg::*;
#(
  parameter int unsigned PAGE_TICKS = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       op_sel_a,
  input  logic       op_sel_b,
  input  logic       btn_page,
  input  logic       result_valid,
  input  logic       result_hi_nz,
  output logic       result_ack,
  output logic [1:0] display_mode,
  output logic [1:0] chosen_operand,
  output logic       result_page,
  output logic       page_dot
);

  if (PAGE_TICKS < 2) begin : g_bad_ticks
    $error("PAGE_TICKS must be at least 2");
  end

  state_e state_q;
  logic   hi_nz_q;
  logic   ack_pend_q;
  logic   accept;
  logic   page_btn;
  logic   wrap;

  // ack_pend_q covers the gap between accept and the ack cycle so valid is not re-taken.
  assign accept   = result_valid && !ack_pend_q && !result_ack;
  assign page_btn = btn_page && (state_q == SHOW_RES) && hi_nz_q;

`ifdef DISPLAY_SEQ_AUTO_PAGE_EN
  logic timer_run;
  logic timer_restart;

  assign timer_run     = (state_q == SHOW_RES) && hi_nz_q;
  assign timer_restart = clear || accept || op_sel_a || op_sel_b || page_btn;

  page_timer #(
    .PAGE_TICKS(PAGE_TICKS)
  ) u_page_timer (
    .clk    (clk),
    .reset  (reset),
    .run    (timer_run),
    .restart(timer_restart),
    .wrap   (wrap)
  );
`else
  assign wrap = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      hi_nz_q        <= 1'b0;
      ack_pend_q     <= 1'b0;
      result_ack     <= 1'b0;
      display_mode   <= MODE_BLANK;
      chosen_operand <= OPERAND_NONE;
      result_page    <= 1'b0;
      page_dot       <= 1'b0;
    end else begin
      ack_pend_q <= 1'b0;
      result_ack <= ack_pend_q;
      if (clear) begin
        state_q        <= IDLE;
        hi_nz_q        <= 1'b0;
        display_mode   <= MODE_BLANK;
        chosen_operand <= OPERAND_NONE;
        result_page    <= 1'b0;
        page_dot       <= 1'b0;
      end else if (accept) begin
        state_q        <= SHOW_RES;
        hi_nz_q        <= result_hi_nz;
        ack_pend_q     <= 1'b1;
        display_mode   <= MODE_RESULT;
        chosen_operand <= OPERAND_NONE;
        result_page    <= 1'b0;
        page_dot       <= 1'b0;
      end else if (op_sel_a || op_sel_b) begin
        state_q        <= op_sel_a ? SHOW_A : SHOW_B;
        hi_nz_q        <= 1'b0;
        display_mode   <= MODE_OPERAND;
        chosen_operand <= op_sel_a ? OPERAND_A : OPERAND_B;
        result_page    <= 1'b0;
        page_dot       <= 1'b0;
      end else if (page_btn || wrap) begin
        result_page <= !result_page;
        page_dot    <= !result_page;
      end
    end
  end

endmodule

// File: tb/tb_display_sequencer.sv
// Directed self-checking bench for display_sequencer with PAGE_TICKS=8.
module tb_display_sequencer;
  import display_seq_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clear = 1'b0;
  logic       op_sel_a = 1'b0;
  logic       op_sel_b = 1'b0;
  logic       btn_page = 1'b0;
  logic       result_valid = 1'b0;
  logic       result_hi_nz = 1'b0;
  logic       result_ack;
  logic [1:0] display_mode;
  logic [1:0] chosen_operand;
  logic       result_page;
  logic       page_dot;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  display_sequencer #(
    .PAGE_TICKS(8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .clear         (clear),
    .op_sel_a      (op_sel_a),
    .op_sel_b      (op_sel_b),
    .btn_page      (btn_page),
    .result_valid  (result_valid),
    .result_hi_nz  (result_hi_nz),
    .result_ack    (result_ack),
    .display_mode  (display_mode),
    .chosen_operand(chosen_operand),
    .result_page   (result_page),
    .page_dot      (page_dot)
  );

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick();
    checks++;
    if ({display_mode, chosen_operand, result_page, page_dot, result_ack} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: got mode=%b op=%b page=%b dot=%b ack=%b required all 0",
               display_mode, chosen_operand, result_page, page_dot, result_ack);
    end
    op_sel_a = 1'b1;
    tick();
    op_sel_a = 1'b0;
    checks++;
    if ({display_mode, chosen_operand} !== 4'b0101) begin
      errors++;
      $display("FAIL reset_sel_a: got mode=%b op=%b required 01/01", display_mode, chosen_operand);
    end
  endtask

  task automatic test_handshake;
    result_valid = 1'b1;
    result_hi_nz = 1'b0;
    tick();
    checks++;
    if ({display_mode, chosen_operand, result_ack} !== 5'b10000) begin
      errors++;
      $display("FAIL hs_accept: got mode=%b op=%b ack=%b required 10/00/0",
               display_mode, chosen_operand, result_ack);
    end
    tick();
    checks++;
    if (result_ack !== 1'b1) begin
      errors++;
      $display("FAIL hs_ack: got %b required 1", result_ack);
    end
    result_valid = 1'b0;
    tick();
    checks++;
    if ({display_mode, result_ack} !== 3'b100) begin
      errors++;
      $display("FAIL hs_ack_drop: got mode=%b ack=%b required 10/0", display_mode, result_ack);
    end
    btn_page = 1'b1;
    tick();
    btn_page = 1'b0;
    checks++;
    if ({result_page, page_dot} !== 2'b00) begin
      errors++;
      $display("FAIL hs_btn_narrow: got page=%b dot=%b required 0/0", result_page, page_dot);
    end
  endtask

  task automatic test_wide_result;
    result_valid = 1'b1;
    result_hi_nz = 1'b1;
    tick();
    tick();
    result_valid = 1'b0;
    checks++;
    if ({result_ack, result_page} !== 2'b10) begin
      errors++;
      $display("FAIL wide_ack: got ack=%b page=%b required 1/0", result_ack, result_page);
    end
`ifdef DISPLAY_SEQ_AUTO_PAGE_EN
    tick(6);
    checks++;
    if (result_page !== 1'b0) begin
      errors++;
      $display("FAIL auto_before_wrap: got %b required 0", result_page);
    end
    tick();
    checks++;
    if ({result_page, page_dot} !== 2'b11) begin
      errors++;
      $display("FAIL auto_wrap1: got page=%b dot=%b required 1/1", result_page, page_dot);
    end
    tick(7);
    checks++;
    if (result_page !== 1'b1) begin
      errors++;
      $display("FAIL auto_hold1: got %b required 1", result_page);
    end
    tick();
    checks++;
    if ({result_page, page_dot} !== 2'b00) begin
      errors++;
      $display("FAIL auto_wrap2: got page=%b dot=%b required 0/0", result_page, page_dot);
    end
    tick(3);
    btn_page = 1'b1;
    tick();
    btn_page = 1'b0;
    checks++;
    if ({result_page, page_dot} !== 2'b11) begin
      errors++;
      $display("FAIL auto_btn: got page=%b dot=%b required 1/1", result_page, page_dot);
    end
    tick(7);
    checks++;
    if (result_page !== 1'b1) begin
      errors++;
      $display("FAIL auto_btn_restart: got %b required 1", result_page);
    end
    tick();
    checks++;
    if (result_page !== 1'b0) begin
      errors++;
      $display("FAIL auto_btn_wrap: got %b required 0", result_page);
    end
`else
    tick(10);
    checks++;
    if (result_page !== 1'b0) begin
      errors++;
      $display("FAIL manual_no_auto: got %b required 0", result_page);
    end
    btn_page = 1'b1;
    tick();
    btn_page = 1'b0;
    checks++;
    if ({result_page, page_dot} !== 2'b11) begin
      errors++;
      $display("FAIL manual_btn1: got page=%b dot=%b required 1/1", result_page, page_dot);
    end
    tick(10);
    btn_page = 1'b1;
    tick();
    btn_page = 1'b0;
    checks++;
    if ({result_page, page_dot} !== 2'b00) begin
      errors++;
      $display("FAIL manual_btn2: got page=%b dot=%b required 0/0", result_page, page_dot);
    end
`endif
    // Leaving SHOW_RES at page 1 must drop the page and dot.
    btn_page = 1'b1;
    tick();
    btn_page = 1'b0;
    op_sel_b = 1'b1;
    tick();
    op_sel_b = 1'b0;
    checks++;
    if ({display_mode, chosen_operand, result_page, page_dot} !== 6'b011000) begin
      errors++;
      $display("FAIL wide_leave: got mode=%b op=%b page=%b dot=%b required 01/10/0/0",
               display_mode, chosen_operand, result_page, page_dot);
    end
  endtask

  task automatic test_priority;
    clear        = 1'b1;
    result_valid = 1'b1;
    result_hi_nz = 1'b0;
    op_sel_a     = 1'b1;
    tick();
    clear    = 1'b0;
    op_sel_a = 1'b0;
    checks++;
    if ({display_mode, chosen_operand, result_ack} !== 5'b00000) begin
      errors++;
      $display("FAIL prio_clear: got mode=%b op=%b ack=%b required 00/00/0",
               display_mode, chosen_operand, result_ack);
    end
    tick();
    checks++;
    if ({display_mode, result_ack} !== 3'b100) begin
      errors++;
      $display("FAIL prio_accept: got mode=%b ack=%b required 10/0", display_mode, result_ack);
    end
    tick();
    result_valid = 1'b0;
    checks++;
    if (result_ack !== 1'b1) begin
      errors++;
      $display("FAIL prio_ack: got %b required 1", result_ack);
    end
    tick();
    checks++;
    if (result_ack !== 1'b0) begin
      errors++;
      $display("FAIL prio_ack_end: got %b required 0", result_ack);
    end
  endtask

  task automatic test_simultaneous_ops;
    op_sel_a = 1'b1;
    op_sel_b = 1'b1;
    tick();
    op_sel_a = 1'b0;
    checks++;
    if ({display_mode, chosen_operand} !== 4'b0101) begin
      errors++;
      $display("FAIL ops_both: got mode=%b op=%b required 01/01", display_mode, chosen_operand);
    end
    tick();
    op_sel_b = 1'b0;
    checks++;
    if ({display_mode, chosen_operand, result_page} !== 5'b01100) begin
      errors++;
      $display("FAIL ops_b: got mode=%b op=%b page=%b required 01/10/0",
               display_mode, chosen_operand, result_page);
    end
  endtask

  task automatic test_reset_mid;
    int acks;
    result_valid = 1'b1;
    result_hi_nz = 1'b1;
    tick();
    btn_page = 1'b1;
    tick();
    btn_page = 1'b0;
    checks++;
    if ({result_ack, result_page, page_dot} !== 3'b111) begin
      errors++;
      $display("FAIL mid_setup: got ack=%b page=%b dot=%b required 1/1/1",
               result_ack, result_page, page_dot);
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({display_mode, chosen_operand, result_page, page_dot, result_ack} !== 7'b0) begin
      errors++;
      $display("FAIL mid_reset: got mode=%b op=%b page=%b dot=%b ack=%b required all 0",
               display_mode, chosen_operand, result_page, page_dot, result_ack);
    end
    reset = 1'b0;
    tick();
    checks++;
    if ({display_mode, result_ack, result_page} !== 4'b1000) begin
      errors++;
      $display("FAIL mid_reaccept: got mode=%b ack=%b page=%b required 10/0/0",
               display_mode, result_ack, result_page);
    end
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (result_ack === 1'b1) begin
        acks++;
        result_valid = 1'b0;
      end
    end
    checks++;
    if (acks !== 1) begin
      errors++;
      $display("FAIL mid_one_ack: got %0d acks required 1", acks);
    end
  endtask

  initial begin
    test_reset();
    test_handshake();
    test_wide_result();
    test_priority();
    test_simultaneous_ops();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
